// File: rtl/fft_pkg.sv
// Shared types for the FFT sample loader: sample width, loader FSM states, byte phase.
package fft_pkg;
   localparam int BYTE_W   = 8;
   localparam int SAMPLE_W = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } loader_state_e;

   typedef enum logic {
      HI = 1'b0,
      LO = 1'b1
   } byte_phase_e;
endpackage

// File: rtl/fft_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port with reset.
module fft_sample_ram
   import fft_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  sample_t           wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output sample_t           rd_data_o
);

   sample_t mem_q [DEPTH];
   sample_t rd_data_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Only the read register is reset; array contents are left undefined.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_sample_loader.sv
// Packs SPI byte pairs (MSB first) into 16-bit samples and fills an FFT frame buffer.
// Optional FFT_LOADER_PINGPONG_EN: two banks so filling continues while the FFT reads.
//
// state | meaning
// FILL  | no complete frame pending; bytes are packed into the fill bank
// FULL  | a complete frame is held for the FFT (frame_ready=1) until frame_ack
module fft_sample_loader
   import fft_pkg::*;
#(
   parameter  int N_POINTS = 64,
   localparam int ADDR_W   = $clog2(N_POINTS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        byte_in,
   input  logic              send_complete,
   input  logic              slave_sel,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [15:0]       rd_data,
   output logic              frame_ready,
   input  logic              frame_ack,
   output logic [ADDR_W:0]   fill_count,
   output logic              overrun
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(N_POINTS);

   logic          sc_q;
   logic          ss_q;
   logic [7:0]    hi_q;
   byte_phase_e   phase_q;
   loader_state_e state_q;
   logic [ADDR_W:0] fill_count_q;
   logic          frame_ready_q;
   logic          overrun_q;

   logic            accept_d;
   logic            ss_rise_d;
   logic [ADDR_W:0] fill_inc_d;
   logic            wr_en_d;
   sample_t         wr_data_d;

   assign accept_d   = send_complete & ~sc_q;
   assign ss_rise_d  = slave_sel & ~ss_q;
   assign fill_inc_d = fill_count_q + 1'b1;
   assign wr_data_d  = {hi_q, byte_in};

`ifdef FFT_LOADER_PINGPONG_EN

   logic    fill_bank_q;
   logic    rd_bank_q;
   logic    rd_sel_q;
   logic    bank_done_d;
   sample_t rd_a_d;
   sample_t rd_b_d;

   // The fill bank only stalls when it is full and the other bank is still owned by the FFT.
   assign wr_en_d     = accept_d && (phase_q == LO) && (fill_count_q != FULL_CNT);
   assign bank_done_d = wr_en_d && (fill_inc_d == FULL_CNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         sc_q          <= 1'b0;
         ss_q          <= 1'b1;
         hi_q          <= '0;
         phase_q       <= HI;
         state_q       <= FILL;
         fill_count_q  <= '0;
         frame_ready_q <= 1'b0;
         overrun_q     <= 1'b0;
         fill_bank_q   <= 1'b0;
         rd_bank_q     <= 1'b0;
         rd_sel_q      <= 1'b0;
      end else begin
         sc_q     <= send_complete;
         ss_q     <= slave_sel;
         rd_sel_q <= rd_bank_q;

         if (accept_d) begin
            if (fill_count_q == FULL_CNT) begin
               overrun_q <= 1'b1;
            end else if (phase_q == HI) begin
               hi_q    <= byte_in;
               phase_q <= LO;
            end else begin
               phase_q      <= HI;
               fill_count_q <= fill_inc_d;
            end
         end

         case (state_q)
            FILL: begin
               if (bank_done_d) begin
                  state_q       <= FULL;
                  frame_ready_q <= 1'b1;
                  rd_bank_q     <= fill_bank_q;
                  fill_bank_q   <= ~fill_bank_q;
                  fill_count_q  <= '0;
               end
            end
            FULL: begin
               if (frame_ack) begin
                  // A second full bank is handed over without dropping frame_ready.
                  if (bank_done_d || (fill_count_q == FULL_CNT)) begin
                     rd_bank_q    <= fill_bank_q;
                     fill_bank_q  <= ~fill_bank_q;
                     fill_count_q <= '0;
                  end else begin
                     state_q       <= FILL;
                     frame_ready_q <= 1'b0;
                  end
               end
            end
            default: state_q <= FILL;
         endcase

         if (ss_rise_d) begin
            phase_q <= HI;
         end
      end
   end

   fft_sample_ram #(.DEPTH(N_POINTS), .ADDR_W(ADDR_W)) u_ram_a (
      .clk_i     (clk),
      .reset_i   (reset),
      .we_i      (wr_en_d & ~fill_bank_q),
      .wr_addr_i (fill_count_q[ADDR_W-1:0]),
      .wr_data_i (wr_data_d),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_a_d)
   );

   fft_sample_ram #(.DEPTH(N_POINTS), .ADDR_W(ADDR_W)) u_ram_b (
      .clk_i     (clk),
      .reset_i   (reset),
      .we_i      (wr_en_d & fill_bank_q),
      .wr_addr_i (fill_count_q[ADDR_W-1:0]),
      .wr_data_i (wr_data_d),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_b_d)
   );

   assign rd_data = rd_sel_q ? rd_b_d : rd_a_d;

`else

   sample_t rd_d;

   assign wr_en_d = accept_d && (state_q == FILL) && (phase_q == LO);

   always_ff @(posedge clk) begin
      if (reset) begin
         sc_q          <= 1'b0;
         ss_q          <= 1'b1;
         hi_q          <= '0;
         phase_q       <= HI;
         state_q       <= FILL;
         fill_count_q  <= '0;
         frame_ready_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         sc_q <= send_complete;
         ss_q <= slave_sel;

         case (state_q)
            FILL: begin
               if (accept_d) begin
                  if (phase_q == HI) begin
                     hi_q    <= byte_in;
                     phase_q <= LO;
                  end else begin
                     phase_q      <= HI;
                     fill_count_q <= fill_inc_d;
                     if (fill_inc_d == FULL_CNT) begin
                        state_q       <= FULL;
                        frame_ready_q <= 1'b1;
                     end
                  end
               end
            end
            FULL: begin
               if (accept_d) begin
                  overrun_q <= 1'b1;
               end
               if (frame_ack) begin
                  state_q       <= FILL;
                  frame_ready_q <= 1'b0;
                  fill_count_q  <= '0;
                  phase_q       <= HI;
               end
            end
            default: state_q <= FILL;
         endcase

         // End of SPI transaction: a lone high byte is discarded, a completing write still lands.
         if (ss_rise_d) begin
            phase_q <= HI;
         end
      end
   end

   fft_sample_ram #(.DEPTH(N_POINTS), .ADDR_W(ADDR_W)) u_ram (
      .clk_i     (clk),
      .reset_i   (reset),
      .we_i      (wr_en_d),
      .wr_addr_i (fill_count_q[ADDR_W-1:0]),
      .wr_data_i (wr_data_d),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_d)
   );

   assign rd_data = rd_d;

`endif

   assign frame_ready = frame_ready_q;
   assign fill_count  = fill_count_q;
   assign overrun     = overrun_q;

endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
- Downstream consumer of spi_interface.
- Takes each received SPI byte (data_out, qualified by send_complete) and packs byte pairs into 16-bit signed samples, MSB byte first.
- Writes samples sequentially into an N_POINTS-deep frame buffer. When the frame is full, raises frame_ready to the FFT core, which reads the buffer through a registered read port and releases it with frame_ack.

Parameters:
- N_POINTS, 64, samples per FFT frame; power of two, 8..1024.
- ADDR_W, $clog2(N_POINTS), buffer address width; derived, do not override.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- byte_in  input  8  received SPI byte (spi_interface data_out)
- send_complete  input  1  level from spi_interface; high while byte_in is valid
- slave_sel  input  1  SPI chip select, active low; clk-synchronous
- rd_addr  input  ADDR_W  FFT read address
- rd_data  output  16  sample at rd_addr, registered
- frame_ready  output  1  full frame available to FFT
- frame_ack  input  1  FFT done with frame; single-cycle pulse
- fill_count  output  ADDR_W+1  samples written into the frame being filled
- overrun  output  1  sticky: a byte arrived while no buffer was free

Behaviour:
- Reset values: rd_data=0, frame_ready=0, fill_count=0, overrun=0; byte phase=HI; state=FILL. Buffer contents are undefined after reset.
- Byte accept: on the cycle where send_complete=1 and its registered previous value=0, accept one byte. A held-high send_complete accepts exactly one byte.
- Phase HI: latch byte_in into hi_reg, phase->LO.
- Phase LO: write {hi_reg, byte_in} to mem[fill_count[ADDR_W-1:0]], fill_count++, phase->HI. Write occurs in the accept cycle.
- Resync: a slave_sel rising edge (end of transaction) forces phase->HI and discards a half-received sample. fill_count is unaffected. If this coincides with an accept in LO phase, the write completes first.
- FSM FILL: when the write that brings fill_count to N_POINTS occurs, the next cycle goes to FULL with frame_ready=1.
- FSM FULL: accepted bytes are dropped and overrun is set. On frame_ack=1: next cycle frame_ready=0, fill_count=0, phase=HI, state=FILL. frame_ack in FILL is ignored.
- Same-cycle accept and frame_ack in FULL: the byte is dropped (overrun set), then the state returns to FILL.
- Read port: rd_data <= mem[rd_addr] every cycle, 1-cycle latency, valid in any state. Reads of addresses not yet written in this frame return stale data.
- overrun clears only on reset.
- Reset mid-frame discards the partial frame and half sample.

Optional Feature:
- Macro: FFT_LOADER_PINGPONG_EN
- Defined: two banks. Filling bank A completes the frame -> frame_ready=1, rd port maps to A, filling continues into B immediately with fill_count=0 and no drop. overrun is set only if B also fills before frame_ack. On ack, banks swap roles; if B is already full, frame_ready stays high (deasserts 1 cycle then reasserts is NOT allowed; it must stay continuously high).
- Undefined: single bank, behaviour as above.

Decomposition:
- Package fft_pkg: BYTE_W=8, SAMPLE_W=16, typedef sample_t (logic signed [15:0]), loader_state_e {FILL, FULL}, byte_phase_e {HI, LO}.
- Sub-module fft_sample_ram: simple dual-port RAM, 1 write/1 registered read, parameterised depth. Instantiated once (twice under PINGPONG).

Test Plan:
- Bytes 0x12,0x34 with send_complete pulses -> mem[0]=0x1234, fill_count=1; rd_addr=0 -> rd_data=0x1234 next cycle.
- 128 bytes with value=index (N_POINTS=64) -> frame_ready rises the cycle after the 128th accept; mem[k]={2k,2k+1}; overrun=0.
- In FULL, send 2 more bytes, then frame_ack -> overrun=1, frame_ready=0, fill_count=0; the next byte pair lands at mem[0].
- Byte 0xAB, slave_sel rises, then 0xCD,0xEF -> mem[0]=0xCDEF (0xAB discarded).
- send_complete held high 10 cycles -> exactly one byte accepted.
- PINGPONG: 192 bytes with no ack -> frame_ready=1, bank B fill_count=64, overrun=0; 2 more bytes -> overrun=1; frame_ack -> frame_ready stays 1, reads return bank B.
